sipo_rx: RTL and testbench
==========================

# sipo_rx

Serial-in/parallel-out word receiver: the receiving end of the design's MSB-first 4-bit parallel-to-serial link. It deserializes a framed serial bit stream into WIDTH-bit words. Each completed word is presented on a valid/ready output port with a one-word holding register. Framing errors and overruns are reported on sticky flags.

## Interface
- WIDTH, 4, word length in bits; legal range 2..32.
- MSB_FIRST, 1, 1: first received bit lands in dout[WIDTH-1]; 0: first bit lands in dout[0].

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset. One clock; reset is asynchronous and active-high.
- sin  in  1  serial data bit.
- sin_en  in  1  qualifies sin; a bit is accepted only on an edge with sin_en=1.
- sync  in  1  start-of-word marker; meaningful only with sin_en=1. The bit accepted with sync=1 is bit 0 of a new word.
- dout  out  WIDTH  received word; stable while dout_valid=1.
- dout_valid  out  1  holding register contains an unread word.
- dout_ready  in  1  consumer accepts dout on an edge where dout_valid=1.
- overrun  out  1  sticky; a completed word was dropped because the holding register was full.
- frame_err  out  1  sticky; a partial word was aborted by sync.
- clr_flags  in  1  synchronous clear of overrun and frame_err.

## Operation
- Reset values (immediate on rst assertion, no clock needed): state=HUNT, bit counter=0, shift register=0, dout=0, dout_valid=0, overrun=0, frame_err=0.
- State HUNT:
  - Accepted bits with sync=0 are discarded.
  - An accepted bit with sync=1 is stored as bit 0, counter=1, next state SHIFT.
- State SHIFT:
  - Each accepted bit is stored at position counter, and the counter increments.
  - MSB_FIRST=1: bit i goes to index WIDTH-1-i. MSB_FIRST=0: bit i goes to index i.
- Word complete: an accepted bit with counter=WIDTH-1.
  - The assembled word, including this bit, is offered to the holding register.
  - Counter returns to 0 and state returns to HUNT.
  - The next word must begin with sync.
- Holding register load:
  - Loads if dout_valid=0, or if dout_valid=1 and dout_ready=1 on the same edge (simultaneous drain and fill).
  - After a load, dout_valid=1.
  - Otherwise the completed word is dropped, dout is unchanged, and overrun is set to 1.
- Drain: dout_valid=1 and dout_ready=1 with no word completing on that edge sets dout_valid to 0. dout keeps its last value.
- sync in SHIFT (accepted bit with sync=1 while counter≠0):
  - The partial word is discarded and frame_err is set to 1.
  - This bit becomes bit 0 of a new word (counter=1) and the state stays SHIFT.
- sync together with the final bit (counter=WIDTH-1, sync=1) is a framing error:
  - The partial word is discarded, frame_err is set to 1, the bit becomes bit 0, and counter=1.
  - Nothing is offered to the holding register.
- Flag precedence: clr_flags clears both flags. A set event on the same edge wins; the flag reads 1 afterwards.
- sin_en=0 edges: counter and shift register hold; sync and sin are ignored.
- Unused shift-register positions hold stale bits. Every position is overwritten before a word completes, so stale bits never reach dout.

## Timing
- Latency: the final bit is accepted at edge k. dout and dout_valid update at edge k and are visible in the cycle after k. There is no added pipeline stage.
- Minimum word time: WIDTH consecutive sin_en cycles. Back-to-back words are sustained at full rate when the consumer holds dout_ready=1.
- Gaps of any length in sin_en are allowed mid-word. The counter holds across gaps.
- dout_valid/dout obey valid/ready: once valid, they do not change until an edge with dout_ready=1.
- Reset mid-word or with a word held: everything returns to reset values asynchronously. The partial word and held word are lost, and no flag is set.
- Reset deassertion: the first accepted bit is evaluated on the first rising edge after rst falls.

## Test plan
- WIDTH=4, MSB_FIRST=1, dout_ready=1; bits 1,0,1,1 on consecutive edges with sync on the first -> dout=4'hB and dout_valid=1 the cycle after the 4th edge; dout_valid falls one cycle later.
- Same bits with MSB_FIRST=0 and sin_en toggled 1/0 between bits -> dout=4'hD. The 3 idle cycles between bits change nothing.
- dout_ready=0; word 4'hA then word 4'h5 -> dout stays 4'hA, dout_valid=1, overrun=1. Raising dout_ready for one edge drains 4'hA. A clr_flags pulse then gives overrun=0.
- dout_ready=1 with dout_valid=1 exactly on the edge the next word (4'h3) completes -> dout=4'h3, dout_valid stays 1, overrun=0.
- Bits 1,1 (sync on the first), then sync with 0,1,0,1 -> frame_err=1 and dout=4'h5. Bits received in HUNT without sync are ignored.
- Assert rst asynchronously after 2 bits with a word held -> all outputs read 0 immediately. After release, 1,1,1,1 with sync -> dout=4'hF.

Source files
------------

// File: rtl/sipo_rx.sv
// Serial-in/parallel-out word receiver with sync framing, a one-word valid/ready
// holding register, and sticky overrun / framing-error flags.
module sipo_rx #(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sin,
   input  logic             sin_en,
   input  logic             sync,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             overrun,
   output logic             frame_err,
   input  logic             clr_flags
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic {HUNT, SHIFT} state_t;

   state_t           state, state_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic [WIDTH-1:0] shreg, shreg_n;
   logic [WIDTH-1:0] dout_n;
   logic             dout_valid_n;
   logic             overrun_n, frame_err_n;
   logic             word_done, ferr_set, load;
   logic [CW-1:0]    pos;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= HUNT;
         cnt        <= '0;
         shreg      <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
         overrun    <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         shreg      <= shreg_n;
         dout       <= dout_n;
         dout_valid <= dout_valid_n;
         overrun    <= overrun_n;
         frame_err  <= frame_err_n;
      end
   end

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      shreg_n   = shreg;
      word_done = 1'b0;
      ferr_set  = 1'b0;
      pos       = '0;
      if (sin_en) begin
         if (sync) begin
            // A sync always restarts the word; any partial word (even one
            // waiting only on its final bit) is a framing error.
            ferr_set = (state == SHIFT);
            pos      = MSB_FIRST ? CW'(WIDTH - 1) : '0;
            shreg_n[pos] = sin;
            cnt_n    = CW'(1);
            state_n  = SHIFT;
         end else if (state == SHIFT) begin
            pos = MSB_FIRST ? (CW'(WIDTH - 1) - cnt) : cnt;
            shreg_n[pos] = sin;
            if (cnt == CW'(WIDTH - 1)) begin
               word_done = 1'b1;
               cnt_n     = '0;
               state_n   = HUNT;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
      end
   end

   always_comb begin
      load         = word_done && (!dout_valid || dout_ready);
      dout_n       = dout;
      dout_valid_n = dout_valid;
      if (load) begin
         dout_n       = shreg_n;
         dout_valid_n = 1'b1;
      end else if (dout_valid && dout_ready) begin
         dout_valid_n = 1'b0;
      end
      overrun_n   = (word_done && !load) || (overrun && !clr_flags);
      frame_err_n = ferr_set || (frame_err && !clr_flags);
   end

endmodule

// File: tb/tb_sipo_rx.sv
// Directed bench for sipo_rx: a per-cycle vector table on an MSB-first instance,
// plus sequences for LSB-first with sin_en gaps and asynchronous reset.
module tb_sipo_rx;

   logic       clk = 1'b0;
   logic       rst;
   logic       sin, sin_en, sync, dout_ready, clr_flags;
   logic [3:0] dout_m, dout_l;
   logic       dv_m, dv_l, ov_m, ov_l, fe_m, fe_l;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   sipo_rx #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
      .clk(clk), .rst(rst), .sin(sin), .sin_en(sin_en), .sync(sync),
      .dout(dout_m), .dout_valid(dv_m), .dout_ready(dout_ready),
      .overrun(ov_m), .frame_err(fe_m), .clr_flags(clr_flags)
   );

   sipo_rx #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .rst(rst), .sin(sin), .sin_en(sin_en), .sync(sync),
      .dout(dout_l), .dout_valid(dv_l), .dout_ready(dout_ready),
      .overrun(ov_l), .frame_err(fe_l), .clr_flags(clr_flags)
   );

   // en sy si rdy clr | expected dout | expected valid ov fe
   typedef struct packed {
      logic       en, sy, si, rdy, clr;
      logic [3:0] d;
      logic       v, ov, fe;
   } vec_t;

   vec_t tbl [42];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic en, input logic sy, input logic si,
                        input logic rdy, input logic clr);
      @(negedge clk);
      sin_en = en; sync = sy; sin = si; dout_ready = rdy; clr_flags = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      sin_en = 1'b0; sync = 1'b0; sin = 1'b0; dout_ready = 1'b0; clr_flags = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      tbl[0]  = 12'b11110_0000_000;
      tbl[1]  = 12'b10010_0000_000;
      tbl[2]  = 12'b10110_0000_000;
      tbl[3]  = 12'b10110_1011_100;
      tbl[4]  = 12'b00010_1011_000;
      tbl[5]  = 12'b10110_1011_000;
      tbl[6]  = 12'b10010_1011_000;
      tbl[7]  = 12'b11100_1011_000;
      tbl[8]  = 12'b10000_1011_000;
      tbl[9]  = 12'b10100_1011_000;
      tbl[10] = 12'b10000_1010_100;
      tbl[11] = 12'b11000_1010_100;
      tbl[12] = 12'b10100_1010_100;
      tbl[13] = 12'b10000_1010_100;
      tbl[14] = 12'b10100_1010_110;
      tbl[15] = 12'b00010_1010_010;
      tbl[16] = 12'b00001_1010_000;
      tbl[17] = 12'b11100_1010_000;
      tbl[18] = 12'b10000_1010_000;
      tbl[19] = 12'b10000_1010_000;
      tbl[20] = 12'b10100_1001_100;
      tbl[21] = 12'b11000_1001_100;
      tbl[22] = 12'b10000_1001_100;
      tbl[23] = 12'b10100_1001_100;
      tbl[24] = 12'b10110_0011_100;
      tbl[25] = 12'b00010_0011_000;
      tbl[26] = 12'b11110_0011_000;
      tbl[27] = 12'b10110_0011_000;
      tbl[28] = 12'b11010_0011_001;
      tbl[29] = 12'b10110_0011_001;
      tbl[30] = 12'b10010_0011_001;
      tbl[31] = 12'b10110_0101_101;
      tbl[32] = 12'b00010_0101_001;
      tbl[33] = 12'b11110_0101_001;
      tbl[34] = 12'b11011_0101_001;
      tbl[35] = 12'b00011_0101_000;
      tbl[36] = 12'b10110_0101_000;
      tbl[37] = 12'b10110_0101_000;
      tbl[38] = 12'b11010_0101_001;
      tbl[39] = 12'b10110_0101_001;
      tbl[40] = 12'b10110_0101_001;
      tbl[41] = 12'b10010_0110_101;

      rst = 1'b1;
      sin_en = 1'b0; sync = 1'b0; sin = 1'b0; dout_ready = 1'b0; clr_flags = 1'b0;
      #1;
      chk("reset_dout", 32'(dout_m), 32'h0);
      chk("reset_valid", 32'(dv_m), 32'h0);
      chk("reset_overrun", 32'(ov_m), 32'h0);
      chk("reset_frame_err", 32'(fe_m), 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 42; i++) begin
         drive(tbl[i].en, tbl[i].sy, tbl[i].si, tbl[i].rdy, tbl[i].clr);
         chk($sformatf("vec%0d_dout", i), 32'(dout_m), 32'(tbl[i].d));
         chk($sformatf("vec%0d_valid", i), 32'(dv_m), 32'(tbl[i].v));
         chk($sformatf("vec%0d_overrun", i), 32'(ov_m), 32'(tbl[i].ov));
         chk($sformatf("vec%0d_frame_err", i), 32'(fe_m), 32'(tbl[i].fe));
      end

      // LSB-first with three idle sin_en cycles between bits: 1,0,1,1 -> 4'hD
      do_reset();
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      for (int b = 1; b < 4; b++) begin
         for (int g = 0; g < 3; g++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
            chk($sformatf("lsb_gap%0d_%0d_valid", b, g), 32'(dv_l), 32'h0);
            chk($sformatf("lsb_gap%0d_%0d_dout", b, g), 32'(dout_l), 32'h0);
         end
         drive(1'b1, 1'b0, (b == 1) ? 1'b0 : 1'b1, 1'b1, 1'b0);
      end
      chk("lsb_dout", 32'(dout_l), 32'hD);
      chk("lsb_valid", 32'(dv_l), 32'h1);
      chk("lsb_frame_err", 32'(fe_l), 32'h0);
      chk("gap_msb_dout", 32'(dout_m), 32'hB);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("lsb_drain_valid", 32'(dv_l), 32'h0);
      chk("lsb_drain_dout", 32'(dout_l), 32'hD);

      // Asynchronous reset with a word held, overrun set and a partial word
      do_reset();
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("pre_rst_dout", 32'(dout_m), 32'hA);
      chk("pre_rst_overrun", 32'(ov_m), 32'h1);
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_dout", 32'(dout_m), 32'h0);
      chk("async_rst_valid", 32'(dv_m), 32'h0);
      chk("async_rst_overrun", 32'(ov_m), 32'h0);
      chk("async_rst_frame_err", 32'(fe_m), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("post_rst_partial_valid", 32'(dv_m), 32'h0);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("post_rst_dout", 32'(dout_m), 32'hF);
      chk("post_rst_valid", 32'(dv_m), 32'h1);
      chk("post_rst_frame_err", 32'(fe_m), 32'h0);
      chk("post_rst_overrun", 32'(ov_m), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
